// File: rtl/badhri_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, break handling and a valid/ready byte
// output that flags overrun when a completed byte cannot be delivered.
module badhri_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       ovr_clr,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;
    logic             rx_m;
    logic             rx_s;
    logic [1:0]       fill;
    logic             armed;
    logic             byte_done_c;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // After reset the synchronizer must refill and the real line must be seen
    // high before a start bit is accepted, so a frame cut by reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill  <= 2'd0;
            armed <= 1'b0;
        end else begin
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end
            if (fill == 2'd2 && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Receive state machine with registered busy and frame_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= 3'd0;
            shift     <= 8'h00;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (armed && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                            idx   <= 3'd0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rx_s;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK_WAIT;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BREAK_WAIT: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_done_c = (state == STOP) && (cnt == BIT_LAST) && rx_s;

    // Output holding register: a byte completing while the previous one is
    // still pending and not being taken this cycle is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= 8'h00;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (ovr_clr) begin
                overrun <= 1'b0;
            end
            if (byte_done_c) begin
                if (!valid || ready) begin
                    data  <= shift;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
